// File: rtl/reg_file_wb.sv
// reg_file_wb: 2**ADDR_W x DATA_W register file with x0 hardwired to zero, two async read ports, a debug read port and a committed-write counter.
//   clk       rising-edge clock for all state
//   rst       asynchronous active-high reset; clears registers and wr_cnt and forces all read data to zero
//   we        write enable
//   waddr     write destination, decoded one-hot to the array
//   wdata     write-back data
//   raddr1/2  read selects; rdata1/2 are combinational
//   dbg_addr  debug read select; dbg_data is combinational and never forwarded
//   wr_cnt    count of committed writes (we=1, waddr!=0), wraps at 2**32
// Build option: define WRITE_BYPASS_EN to forward wdata to rdata1/2 when the read address matches a committing write.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_cnt
);
  localparam int N = 2 ** ADDR_W;
  logic [DATA_W-1:0] q [N];
  logic [N-1:0]      wstb;
  logic [31:0]       cnt;
  logic [DATA_W-1:0] rd1, rd2, rdd;
  // gating with we keeps an undefined waddr from reaching any strobe while idle
  assign wstb = {N{we}} & ({{(N-1){1'b0}}, 1'b1} << waddr);
  // strobe 0 is never consumed, so writes to x0 are dropped and not counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) q[i] <= '0;
      cnt <= '0;
    end else begin
      for (int i = 1; i < N; i++) if (wstb[i]) q[i] <= wdata;
      if (|wstb[N-1:1]) cnt <= cnt + 32'd1;
    end
  end
  always_comb begin
    rd1 = (raddr1 == '0) ? '0 : q[raddr1];
    rd2 = (raddr2 == '0) ? '0 : q[raddr2];
    rdd = (dbg_addr == '0) ? '0 : q[dbg_addr];
  end
`ifdef WRITE_BYPASS_EN
  logic wvalid;
  assign wvalid = we && (waddr != '0);
  assign rdata1 = rst ? '0 : (wvalid && raddr1 == waddr) ? wdata : rd1;
  assign rdata2 = rst ? '0 : (wvalid && raddr2 == waddr) ? wdata : rd2;
`else
  assign rdata1 = rst ? '0 : rd1;
  assign rdata2 = rst ? '0 : rd2;
`endif
  assign dbg_data = rst ? '0 : rdd;
  assign wr_cnt = rst ? '0 : cnt;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: scoreboard bench for reg_file_wb against a reference model of the register file.
module tb_reg_file_wb;
  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  waddr, raddr1, raddr2, dbg_addr;
  logic [31:0] wdata, rdata1, rdata2, dbg_data, wr_cnt;
  logic [31:0] mdl [32];
  logic [31:0] mcnt;
  int          n_run = 0, n_fail = 0;
  typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  reg_file_wb dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_cnt(wr_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rd(input logic [4:0] a, input bit fwd);
    bit hit;
    hit = fwd && we && waddr != 5'd0 && a == waddr;
`ifndef WRITE_BYPASS_EN
    hit = 1'b0;
`endif
    if (rst) return 32'd0;
    if (hit) return wdata;
    return a == 5'd0 ? 32'd0 : mdl[a];
  endfunction
  task automatic expect_now(input string tag);
    sb.push_back('{{tag, ".rdata1"}, 0, rd(raddr1, 1'b1)});
    sb.push_back('{{tag, ".rdata2"}, 1, rd(raddr2, 1'b1)});
    sb.push_back('{{tag, ".dbg"}, 2, rd(dbg_addr, 1'b0)});
    sb.push_back('{{tag, ".wr_cnt"}, 3, rst ? 32'd0 : mcnt});
  endtask
  task automatic drain();
    exp_t e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.sel == 0 ? rdata1 : e.sel == 1 ? rdata2 : e.sel == 2 ? dbg_data : wr_cnt;
      check(e.tag, got, e.exp);
    end
  endtask
  task automatic sample(input string tag);
    expect_now(tag);
    drain();
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst && we && waddr != 5'd0) begin
      mdl[waddr] = wdata;
      mcnt = mcnt + 32'd1;
    end
    #1;
  endtask
  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2; dbg_addr = d;
    #1;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mcnt = 32'd0;
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h55; raddr1 = 5'd7; raddr2 = 5'd31; dbg_addr = 5'd1;
    #1 sample("reset");
    tick();
    tick();
    raddr1 = 5'd4;
    sample("reset_write_lost");
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd4, 5'd5);
    rst = 1'b0;
    #1 sample("first_write_pre");
    tick();
    sample("first_write");
    drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 5'd0);
    tick();
    sample("x0_write");
    drive(1'b1, 5'd3, 32'h11, 5'd3, 5'd5, 5'd3);
    tick();
    drive(1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 5'd3);
    sample("rdw_pre");
    tick();
    sample("rdw_post");
    drive(1'b0, 5'bx, 32'hFFFF0000, 5'd3, 5'd5, 5'd0);
    waddr = 5'bx;
    tick();
    sample("idle_xaddr");
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      if (i % 7 == 0) raddr1 = waddr;
      if (i % 5 == 0) raddr2 = waddr;
      #1 sample($sformatf("rand%0d", i));
      tick();
    end
    drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 5'd9);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 5'd9);
    sample("pre_async");
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mcnt = 32'd0;
    #1 sample("async_rst");
    #2 rst = 1'b0;
    #1 sample("async_rst_release");
    drive(1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd9, 5'd7);
    dut.cnt = 32'hFFFFFFFF;
    mcnt = 32'hFFFFFFFF;
    #1 sample("wrap_pre");
    tick();
    sample("wrap");
    check("wrap_zero", wr_cnt, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
